// File: rtl/axi_regfile_gen_if.sv
// AXI4-Lite bus bundle for the generic register file.
// Master drives addresses/data/ready-for-response; slave answers.
interface axi_regfile_gen_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_regfile_gen.sv
// Parametrised AXI4-Lite register file with read-only and pulse
// registers, per-register reset values and access strobes.
module axi_regfile_gen #(
    parameter int                           NREGS      = 16,
    parameter int                           DATA_WIDTH = 32,
    parameter int                           ADDR_WIDTH = 6,
    parameter logic [NREGS-1:0]             RO_MASK    = '0,
    parameter logic [NREGS-1:0]             PULSE_MASK = '0,
    parameter logic [NREGS*DATA_WIDTH-1:0]  RESET_VAL  = '0
) (
    input  logic                          axi_aclk,
    input  logic                          axi_reset,
    axi_regfile_gen_if.slave              s_axi,
    output logic [NREGS*DATA_WIDTH-1:0]   slv_reg,
    input  logic [NREGS*DATA_WIDTH-1:0]   slv_read,
    output logic [NREGS-1:0]              wr_stb,
    output logic [NREGS-1:0]              rd_stb
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = ADDR_WIDTH - LSB;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Pulse registers never hold their configured reset value.
    function automatic logic [NREGS*DATA_WIDTH-1:0] reset_image();
        logic [NREGS*DATA_WIDTH-1:0] v;
        v = RESET_VAL;
        for (int k = 0; k < NREGS; k++) begin
            if (PULSE_MASK[k]) v[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
        return v;
    endfunction

    localparam logic [NREGS*DATA_WIDTH-1:0] RST_IMAGE = reset_image();

    logic                        aw_held_q, aw_held_d;
    logic [IW-1:0]               aw_idx_q, aw_idx_d;
    logic                        w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
    logic [NB-1:0]               wstrb_q, wstrb_d;
    logic                        bvalid_q, bvalid_d;
    logic [1:0]                  bresp_q, bresp_d;
    logic                        rvalid_q, rvalid_d;
    logic [1:0]                  rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
    logic [NREGS*DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NREGS-1:0]            wr_stb_q, wr_stb_d;
    logic [NREGS-1:0]            rd_stb_q, rd_stb_d;

    logic                        aw_hs, w_hs, ar_hs, exec;
    logic                        aw_map, ar_map;
    logic [IW-1:0]               ar_idx;
    logic [DATA_WIDTH-1:0]       cur;
    logic                        unused_ok;

    assign s_axi.awready = !aw_held_q && !bvalid_q;
    assign s_axi.wready  = !w_held_q && !bvalid_q;
    assign s_axi.arready = !rvalid_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;

    assign slv_reg = regs_q;
    assign wr_stb  = wr_stb_q;
    assign rd_stb  = rd_stb_q;

    assign aw_hs = s_axi.awvalid && s_axi.awready;
    assign w_hs  = s_axi.wvalid && s_axi.wready;
    assign ar_hs = s_axi.arvalid && s_axi.arready;

    // A beat arriving this cycle counts as held, so the second
    // handshake executes the write at the same edge.
    assign aw_idx_d = aw_hs ? s_axi.awaddr[ADDR_WIDTH-1:LSB] : aw_idx_q;
    assign wdata_d  = w_hs ? s_axi.wdata : wdata_q;
    assign wstrb_d  = w_hs ? s_axi.wstrb : wstrb_q;
    assign exec     = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign aw_held_d = (aw_held_q || aw_hs) && !exec;
    assign w_held_d  = (w_held_q || w_hs) && !exec;

    assign ar_idx = s_axi.araddr[ADDR_WIDTH-1:LSB];
    assign aw_map = 32'(aw_idx_d) < 32'(NREGS);
    assign ar_map = 32'(ar_idx) < 32'(NREGS);

    assign unused_ok = ^{s_axi.awprot, s_axi.arprot,
                         s_axi.awaddr[LSB-1:0], s_axi.araddr[LSB-1:0]};

    always_comb begin
        bvalid_d = bvalid_q && !s_axi.bready;
        bresp_d  = bresp_q;
        wr_stb_d = '0;
        regs_d   = regs_q;
        cur      = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (PULSE_MASK[k]) regs_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
        if (exec) begin
            bvalid_d = 1'b1;
            bresp_d  = aw_map ? OKAY : SLVERR;
            for (int k = 0; k < NREGS; k++) begin
                if (32'(aw_idx_d) == 32'(k) && !RO_MASK[k]) begin
                    cur = regs_d[k*DATA_WIDTH +: DATA_WIDTH];
                    for (int b = 0; b < NB; b++) begin
                        if (wstrb_d[b]) cur[b*8 +: 8] = wdata_d[b*8 +: 8];
                    end
                    regs_d[k*DATA_WIDTH +: DATA_WIDTH] = cur;
                    wr_stb_d[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rvalid_d = rvalid_q && !s_axi.rready;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        rd_stb_d = '0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = ar_map ? OKAY : SLVERR;
            rdata_d  = '0;
            for (int k = 0; k < NREGS; k++) begin
                if (32'(ar_idx) == 32'(k)) begin
                    rdata_d     = slv_read[k*DATA_WIDTH +: DATA_WIDTH];
                    rd_stb_d[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
            regs_q    <= RST_IMAGE;
            wr_stb_q  <= '0;
            rd_stb_q  <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
            wr_stb_q  <= wr_stb_d;
            rd_stb_q  <= rd_stb_d;
        end
    end
endmodule

// File: tb/tb_axi_regfile_gen.sv
// Bench for axi_regfile_gen: transaction-level model plus
// directed vectors with literal expectations.
module tb_axi_regfile_gen;
    localparam int NREGS = 12;
    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam logic [NREGS-1:0] RO = 12'h020;
    localparam logic [NREGS-1:0] PU = 12'h010;
    localparam logic [NREGS*DW-1:0] RV = {
        {6{32'h0}}, 32'hDEAD_0005, 32'hFFFF_FFFF, 32'h0000_1234, {3{32'h0}}
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NREGS*DW-1:0] slv_reg;
    logic [NREGS*DW-1:0] slv_read;
    logic [NREGS-1:0]    wr_stb, rd_stb;

    axi_regfile_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_regfile_gen #(
        .NREGS(NREGS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .RO_MASK(RO), .PULSE_MASK(PU), .RESET_VAL(RV)
    ) dut (
        .axi_aclk(clk), .axi_reset(rst), .s_axi(bus.slave),
        .slv_reg(slv_reg), .slv_read(slv_read),
        .wr_stb(wr_stb), .rd_stb(rd_stb)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [NREGS*DW-1:0] act,
                       input logic [NREGS*DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: pending address/data queues, one
    // outstanding response per channel, register array by index.
    logic [31:0]      m_reg [NREGS];
    int               m_awq [$];
    logic [31:0]      m_wd [$];
    logic [3:0]       m_ws [$];
    logic             m_bvalid, m_rvalid;
    logic [1:0]       m_bresp, m_rresp;
    logic [31:0]      m_rdata;
    logic [NREGS-1:0] m_wr, m_rd;
    bit               started = 0;

    task automatic model_step();
        bit aw_acc, w_acc, ar_acc;
        int idx;
        logic [31:0] d;
        logic [3:0] s;
        if (rst) begin
            foreach (m_reg[k]) m_reg[k] = 32'h0;
            m_reg[3] = 32'h0000_1234;
            m_reg[5] = 32'hDEAD_0005;
            m_awq.delete(); m_wd.delete(); m_ws.delete();
            m_bvalid = 0; m_rvalid = 0; m_bresp = 0; m_rresp = 0;
            m_rdata = 0; m_wr = 0; m_rd = 0;
            started = 1;
        end else begin
            aw_acc = bus.awvalid && m_awq.size() == 0 && !m_bvalid;
            w_acc  = bus.wvalid && m_wd.size() == 0 && !m_bvalid;
            ar_acc = bus.arvalid && !m_rvalid;
            for (int k = 0; k < NREGS; k++) if (PU[k]) m_reg[k] = 0;
            m_wr = 0;
            m_rd = 0;
            if (m_bvalid && bus.bready) m_bvalid = 0;
            if (m_rvalid && bus.rready) m_rvalid = 0;
            if (aw_acc) m_awq.push_back(int'(bus.awaddr) / 4);
            if (w_acc) begin
                m_wd.push_back(bus.wdata);
                m_ws.push_back(bus.wstrb);
            end
            if (m_awq.size() > 0 && m_wd.size() > 0) begin
                idx = m_awq.pop_front();
                d = m_wd.pop_front();
                s = m_ws.pop_front();
                m_bvalid = 1;
                m_bresp = (idx < NREGS) ? 2'b00 : 2'b10;
                if (idx < NREGS && !RO[idx]) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) m_reg[idx][b*8 +: 8] = d[b*8 +: 8];
                    m_wr[idx] = 1;
                end
            end
            if (ar_acc) begin
                idx = int'(bus.araddr) / 4;
                m_rvalid = 1;
                if (idx < NREGS) begin
                    m_rresp = 2'b00;
                    m_rdata = slv_read[idx*DW +: DW];
                    m_rd[idx] = 1;
                end else begin
                    m_rresp = 2'b10;
                    m_rdata = 0;
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        logic [NREGS*DW-1:0] e;
        if (started) begin
            for (int k = 0; k < NREGS; k++) e[k*DW +: DW] = m_reg[k];
            chk("awready", bus.awready, m_awq.size() == 0 && !m_bvalid);
            chk("wready", bus.wready, m_wd.size() == 0 && !m_bvalid);
            chk("arready", bus.arready, !m_rvalid);
            chk("bvalid", bus.bvalid, m_bvalid);
            chk("rvalid", bus.rvalid, m_rvalid);
            if (m_bvalid) chk("bresp", bus.bresp, m_bresp);
            if (m_rvalid) chk("rresp", bus.rresp, m_rresp);
            if (m_rvalid) chk("rdata", bus.rdata, m_rdata);
            chk("slv_reg", slv_reg, e);
            chk("wr_stb", wr_stb, m_wr);
            chk("rd_stb", rd_stb, m_rd);
        end
    end

    task automatic xfer(input bit da, input logic [AW-1:0] aa,
                        input bit dw, input logic [31:0] wd,
                        input logic [3:0] ws,
                        input bit dr, input logic [AW-1:0] ra);
        bit pa, pw, pr;
        int n;
        bus.awaddr = aa; bus.awvalid = da;
        bus.wdata = wd; bus.wstrb = ws; bus.wvalid = dw;
        bus.araddr = ra; bus.arvalid = dr;
        n = 0;
        while ((bus.awvalid || bus.wvalid || bus.arvalid) && n < 20) begin
            pa = bus.awvalid && bus.awready;
            pw = bus.wvalid && bus.wready;
            pr = bus.arvalid && bus.arready;
            @(negedge clk);
            n++;
            if (pa) bus.awvalid = 0;
            if (pw) bus.wvalid = 0;
            if (pr) bus.arvalid = 0;
        end
        chk("handshake", {bus.awvalid, bus.wvalid, bus.arvalid}, 0);
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        xfer(1, a, 1, d, s, 0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        xfer(0, '0, 0, '0, '0, 1, a);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awaddr = 0; bus.awprot = 0; bus.awvalid = 0;
        bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0; bus.bready = 1;
        bus.araddr = 0; bus.arprot = 0; bus.arvalid = 0; bus.rready = 1;
        for (int k = 0; k < NREGS; k++)
            slv_read[k*DW +: DW] = 32'h5100_0000 + 32'(k);
        slv_read[2*DW +: DW] = 32'h0BAD_F00D;

        idle(2);
        rst = 0;
        chk("rst_reg3", slv_reg[3*DW +: DW], 32'h0000_1234);
        chk("rst_reg4_pulse", slv_reg[4*DW +: DW], 32'h0);
        chk("rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        chk("rst_readys", {bus.awready, bus.wready, bus.arready}, 3'b111);

        // W three cycles ahead of AW
        xfer(0, '0, 1, 32'hA5A5_0000, 4'b1100, 0, '0);
        idle(3);
        xfer(1, 6'h0C, 0, '0, '0, 0, '0);
        chk("w_first_reg3", slv_reg[3*DW +: DW], 32'hA5A5_1234);
        chk("w_first_stb", wr_stb, 12'h008);
        chk("w_first_b", {bus.bvalid, bus.bresp}, 3'b100);
        idle(1);
        chk("w_first_stb_off", wr_stb, 12'h000);
        idle(1);

        // read under R back-pressure
        bus.rready = 0;
        rd(6'h08);
        chk("rd_bp_data", bus.rdata, 32'h0BAD_F00D);
        chk("rd_bp_stb", rd_stb, 12'h004);
        slv_read[2*DW +: DW] = 32'h1111_1111;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("rd_bp_hold", {bus.arready, rd_stb, bus.rdata},
                {1'b0, 12'h000, 32'h0BAD_F00D});
        end
        bus.rready = 1;
        idle(1);
        chk("rd_bp_done", bus.rvalid, 1'b0);

        // pulse register
        wr(6'h10, 32'h1, 4'b1111);
        chk("pulse_hi", slv_reg[4*DW +: DW], 32'h1);
        idle(1);
        chk("pulse_lo", slv_reg[4*DW +: DW], 32'h0);
        idle(1);

        // unmapped read and write
        rd(6'h30);
        chk("unmap_r", {bus.rresp, bus.rdata, rd_stb}, {2'b10, 32'h0, 12'h0});
        idle(1);
        wr(6'h3C, 32'hFFFF_FFFF, 4'b1111);
        chk("unmap_w", {bus.bresp, wr_stb}, {2'b10, 12'h0});
        chk("unmap_w_reg3", slv_reg[3*DW +: DW], 32'hA5A5_1234);
        idle(1);

        // read-only register
        wr(6'h14, 32'h1234_5678, 4'b1111);
        chk("ro_w", {bus.bvalid, bus.bresp, wr_stb}, {3'b100, 12'h0});
        chk("ro_reg5", slv_reg[5*DW +: DW], 32'hDEAD_0005);
        idle(1);

        // same-cycle read and write of register 0
        xfer(1, 6'h00, 1, 32'hCAFE_BABE, 4'b1111, 1, 6'h00);
        chk("rw_same_rdata", bus.rdata, 32'h5100_0000);
        chk("rw_same_reg0", slv_reg[0 +: DW], 32'hCAFE_BABE);
        chk("rw_same_stb", {wr_stb, rd_stb}, {12'h001, 12'h001});
        idle(1);

        // byte strobes, AW-first ordering
        wr(6'h04, 32'h1122_3344, 4'b0101);
        chk("strb_0101", slv_reg[1*DW +: DW], 32'h0022_0044);
        idle(1);
        xfer(1, 6'h04, 0, '0, '0, 0, '0);
        idle(1);
        xfer(0, '0, 1, 32'hAABB_CCDD, 4'b1000, 0, '0);
        chk("strb_1000", slv_reg[1*DW +: DW], 32'hAA22_0044);
        idle(1);

        // back-to-back writes and reads
        for (int i = 0; i < 4; i++) begin
            xfer(1, 6'(24 + 4*i), 1, 32'h0101_0101 * 32'(i + 1), 4'b1111,
                 1, 6'(4*i));
        end
        idle(1);
        chk("b2b_reg9", slv_reg[9*DW +: DW], 32'h0404_0404);

        // B back-pressure
        bus.bready = 0;
        wr(6'h28, 32'h0000_00AA, 4'b0001);
        idle(3);
        chk("b_bp_hold", {bus.bvalid, bus.awready, bus.wready}, 3'b100);
        bus.bready = 1;
        idle(2);

        // reset discards a held AW
        xfer(1, 6'h1C, 0, '0, '0, 0, '0);
        chk("held_aw", bus.awready, 1'b0);
        rst = 1;
        idle(1);
        rst = 0;
        chk("rst2_readys", {bus.awready, bus.wready, bus.arready}, 3'b111);
        xfer(0, '0, 1, 32'h0000_0077, 4'b1111, 0, '0);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("lone_w_no_b", bus.bvalid, 1'b0);
        end
        xfer(1, 6'h20, 0, '0, '0, 0, '0);
        chk("after_rst_b", {bus.bvalid, bus.bresp}, 3'b100);
        chk("after_rst_reg8", slv_reg[8*DW +: DW], 32'h0000_0077);
        chk("after_rst_reg7", slv_reg[7*DW +: DW], 32'h0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
